id_ex_stage: RTL



---
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble injection and flush squashing.
// Optional hazard unit: define ID_EX_LOAD_USE_STALL_EN to enable Stall/StallCount.
module id_ex_stage (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        RegDst,
  input  logic        ALUSrc1,
  input  logic        ALUSrc2,
  input  logic        MemToReg,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        SignExtend,
  input  logic        Jal,
  input  logic        Jr,
  input  logic [3:0]  ALUOp,
  input  logic [31:0] Instruction,
  input  logic [31:0] PCPlus4,
  input  logic [31:0] BusA,
  input  logic [31:0] BusB,
  input  logic        Flush,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_MemToReg,
  output logic        ex_Branch,
  output logic        ex_Jump,
  output logic        ex_Jal,
  output logic        ex_Jr,
  output logic        ex_ALUSrc1,
  output logic        ex_ALUSrc2,
  output logic [3:0]  ex_ALUOp,
  output logic [31:0] ex_BusA,
  output logic [31:0] ex_BusB,
  output logic [31:0] ex_Imm32,
  output logic [31:0] ex_PCPlus4,
  output logic [4:0]  ex_Shamt,
  output logic [4:0]  ex_Rs,
  output logic [4:0]  ex_Rt,
  output logic [4:0]  ex_Rw,
  output logic        Stall,
  output logic [15:0] StallCount
);

  logic [9:0]  r_ctrl;
  logic [3:0]  r_alu_op;
  logic [31:0] r_bus_a;
  logic [31:0] r_bus_b;
  logic [31:0] r_imm32;
  logic [31:0] r_pc_plus4;
  logic [4:0]  r_shamt;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rw;

  logic [9:0]  w_ctrl;
  logic [31:0] w_imm32;
  logic [4:0]  w_rw;
  logic        w_bubble;

  assign w_ctrl  = {RegWrite, MemRead, MemWrite, MemToReg, Branch,
                    Jump, Jal, Jr, ALUSrc1, ALUSrc2};
  assign w_imm32 = {{16{SignExtend & Instruction[15]}}, Instruction[15:0]};
  assign w_rw    = Jal ? 5'd31 : (RegDst ? Instruction[15:11] : Instruction[20:16]);

`ifdef ID_EX_LOAD_USE_STALL_EN
  logic        w_rs_used;
  logic        w_rt_used;
  logic        w_hazard;
  logic [15:0] r_stall_count;

  // J and JAL carry a target in the rs field; only R-type, SW and BEQ read rt.
  assign w_rs_used = ~(Jump & ~Jr);
  assign w_rt_used = (Instruction[31:26] == 6'b000000) ||
                     (Instruction[31:26] == 6'b101011) ||
                     (Instruction[31:26] == 6'b000100);
  assign w_hazard  = r_ctrl[8] && (r_rw != 5'd0) &&
                     ((w_rs_used && (Instruction[25:21] == r_rw)) ||
                      (w_rt_used && (Instruction[20:16] == r_rw)));
  assign Stall      = w_hazard & ~Flush;
  assign StallCount = r_stall_count;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_stall_count <= 16'd0;
    end else if (Stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end
`else
  logic w_unused_opcode;
  assign w_unused_opcode = ^Instruction[31:26];
  assign Stall      = 1'b0;
  assign StallCount = 16'd0;
`endif

  assign w_bubble = Flush | Stall;

  // Bubbles clear only control and the destination; data fields load regardless.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_ctrl     <= 10'd0;
      r_alu_op   <= 4'b0000;
      r_bus_a    <= 32'd0;
      r_bus_b    <= 32'd0;
      r_imm32    <= 32'd0;
      r_pc_plus4 <= 32'd0;
      r_shamt    <= 5'd0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_rw       <= 5'd0;
    end else begin
      r_ctrl     <= w_bubble ? 10'd0   : w_ctrl;
      r_alu_op   <= w_bubble ? 4'b0000 : ALUOp;
      r_rw       <= w_bubble ? 5'd0    : w_rw;
      r_bus_a    <= BusA;
      r_bus_b    <= BusB;
      r_imm32    <= w_imm32;
      r_pc_plus4 <= PCPlus4;
      r_shamt    <= Instruction[10:6];
      r_rs       <= Instruction[25:21];
      r_rt       <= Instruction[20:16];
    end
  end

  assign {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_Branch,
          ex_Jump, ex_Jal, ex_Jr, ex_ALUSrc1, ex_ALUSrc2} = r_ctrl;
  assign ex_ALUOp   = r_alu_op;
  assign ex_BusA    = r_bus_a;
  assign ex_BusB    = r_bus_b;
  assign ex_Imm32   = r_imm32;
  assign ex_PCPlus4 = r_pc_plus4;
  assign ex_Shamt   = r_shamt;
  assign ex_Rs      = r_rs;
  assign ex_Rt      = r_rt;
  assign ex_Rw      = r_rw;

endmodule
